// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period and high time of a slow square wave in clk cycles. It is
// the receiving end of the square-wave generator. The asynchronous input is
// synchronised and edge-detected. A free-running counter measures the time
// since the last rising edge. Every complete period produces a one-cycle
// `valid` strobe. If no rising edge arrives within C_MAX_CYCLES, a sticky
// `timeout` level is raised; the next `valid` clears it.
//
// Ports:
//   clk     - master clock
//   rstb    - synchronous active-low reset
//   in      - asynchronous square wave to measure
//   period  - last measured period [clk cycles], 0 after a timeout
//   high    - last measured high time [clk cycles], 0 after a timeout
//   valid   - one-cycle strobe, period/high updated this cycle
//   timeout - level, no rising edge within C_MAX_CYCLES
// -----------------------------------------------------------------------------
module period_meter #(
  parameter int unsigned C_CLK_FRQ     = 100_000_000,
  parameter int unsigned C_MAX_PERIOD  = 1000,
  parameter int unsigned C_SYNC_STAGES = 2,
  localparam longint unsigned C_MAX_CYCLES =
    (64'(C_CLK_FRQ) * 64'(C_MAX_PERIOD)) / 64'd1000,
  localparam int C_WIDTH = $clog2(C_MAX_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               in,
  output logic [C_WIDTH-1:0] period,
  output logic [C_WIDTH-1:0] high,
  output logic               valid,
  output logic               timeout
);

  localparam logic [C_WIDTH-1:0] C_MAX_CNT = C_WIDTH'(C_MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_MEASURE
  } state_t;

  // ---------------------------------------------------------------------------
  // Front end: synchroniser, delay flop, edge detection
  // ---------------------------------------------------------------------------
  logic [C_SYNC_STAGES-1:0] sync_q;
  logic [C_SYNC_STAGES-1:0] primed_q;
  logic                     delayed_q;
  logic                     synced;
  logic                     primed;
  logic                     rise;
  logic                     fall;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of the others, regardless of the
  // order in which the simulator evaluates the processes.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sync_q    <= '0;
      primed_q  <= '0;
      delayed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[C_SYNC_STAGES-2:0], in};
      // A 1 walks through primed_q in step with the first real input sample.
      // Once it reaches the top, `synced` reflects the pin rather than the
      // reset value.
      primed_q  <= {primed_q[C_SYNC_STAGES-2:0], 1'b1};
      delayed_q <= sync_q[C_SYNC_STAGES-1];
    end
  end

  assign synced = sync_q[C_SYNC_STAGES-1];
  assign primed = primed_q[C_SYNC_STAGES-1];
  assign rise   = synced & ~delayed_q;
  assign fall   = ~synced & delayed_q;

  // ---------------------------------------------------------------------------
  // Cycles since the last rising edge, saturating at C_MAX_CYCLES
  // ---------------------------------------------------------------------------
  logic [C_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      count <= '0;
    end else if (rise) begin
      count <= C_WIDTH'(1);
    end else if (count != C_MAX_CNT) begin
      count <= count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_d;
  logic   meas_done;
  logic   meas_timeout;
  logic   capture_high;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state;
    meas_done    = 1'b0;
    meas_timeout = 1'b0;
    capture_high = 1'b0;
    case (state)
      // The synchroniser is cleared by reset, so its output is not trusted
      // until `primed`. This stops a high pin from posing as a reset-release
      // rising edge.
      S_IDLE: begin
        if (primed && !synced) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (rise) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        // A rise in the same cycle as the limit is still a valid measurement.
        if (rise) begin
          meas_done = 1'b1;
        end else if (count == C_MAX_CNT) begin
          meas_timeout = 1'b1;
          state_d      = S_IDLE;
        end else if (fall) begin
          capture_high = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered results
  // ---------------------------------------------------------------------------
  logic [C_WIDTH-1:0] high_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      high_q  <= '0;
      period  <= '0;
      high    <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= meas_done;
      if (capture_high) begin
        high_q <= count;
      end
      if (meas_done) begin
        period  <= count;
        high    <= high_q;
        timeout <= 1'b0;
      end else if (meas_timeout) begin
        period  <= '0;
        high    <= '0;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//
// Self-checking bench for period_meter with a 1000-cycle limit. A timestamp
// model predicts valid/period/high/timeout for every cycle. The model keeps
// the time of the last rising edge and works out periods as time differences.
// Directed scenarios also check the headline numbers against fixed constants.
// A randomized run follows.
// -----------------------------------------------------------------------------
module tb_period_meter;

  localparam int C_SYNC = 2;
  localparam int C_MAXC = 1000;
  localparam int C_W    = 10;

  localparam int P_WAIT_LOW = 0;
  localparam int P_ARMED    = 1;
  localparam int P_MEASURE  = 2;

  logic           clk  = 1'b0;
  logic           rstb = 1'b0;
  logic           in   = 1'b0;
  logic [C_W-1:0] period;
  logic [C_W-1:0] high;
  logic           valid;
  logic           timeout;

  period_meter #(
    .C_CLK_FRQ    (1_000_000),
    .C_MAX_PERIOD (1),
    .C_SYNC_STAGES(C_SYNC)
  ) dut (
    .clk    (clk),
    .rstb   (rstb),
    .in     (in),
    .period (period),
    .high   (high),
    .valid  (valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pin history plus timestamps
  // ---------------------------------------------------------------------------
  bit     mq [0:C_SYNC];   // mq[0] is the newest pin sample
  int     m_phase;
  longint now;
  longint t_rise;
  longint m_hi;
  longint exp_period;
  longint exp_high;
  bit     exp_valid;
  bit     exp_timeout;

  task automatic model_step(input bit x, input bit r);
    bit s;
    bit sp;
    bit m_rise;
    bit m_fall;
    exp_valid = 1'b0;
    if (!r) begin
      for (int i = 0; i <= C_SYNC; i++) mq[i] = 1'b0;
      m_phase     = P_WAIT_LOW;
      now         = 0;
      t_rise      = 0;
      m_hi        = 0;
      exp_period  = 0;
      exp_high    = 0;
      exp_timeout = 1'b0;
      return;
    end
    now++;
    s      = mq[C_SYNC-1];
    sp     = mq[C_SYNC];
    m_rise = s && !sp;
    m_fall = !s && sp;
    case (m_phase)
      P_WAIT_LOW: begin
        // The pin is only known after C_SYNC samples have gone through.
        if (!s && now > C_SYNC) m_phase = P_ARMED;
      end
      P_ARMED: begin
        if (m_rise) begin
          m_phase = P_MEASURE;
          t_rise  = now;
        end
      end
      default: begin
        if (m_fall) m_hi = now - t_rise;
        if (m_rise) begin
          exp_period  = now - t_rise;
          exp_high    = m_hi;
          exp_valid   = 1'b1;
          exp_timeout = 1'b0;
          t_rise      = now;
        end else if (now - t_rise == C_MAXC) begin
          exp_period  = 0;
          exp_high    = 0;
          exp_timeout = 1'b1;
          m_phase     = P_WAIT_LOW;
        end
      end
    endcase
    for (int i = C_SYNC; i > 0; i--) mq[i] = mq[i-1];
    mq[0] = x;
  endtask

  // ---------------------------------------------------------------------------
  // Observations collected per scenario
  // ---------------------------------------------------------------------------
  int             cyc = 0;
  int             n_valid;
  int             last_valid_cyc;
  int             first_valid_cyc;
  int             valid_gap;
  int             to_rise_cyc;
  int             to_fall_cyc;
  bit             to_seen;
  bit             prev_to = 1'b0;
  logic [C_W-1:0] fv_period;
  logic [C_W-1:0] fv_high;
  logic [C_W-1:0] obs_period;
  logic [C_W-1:0] obs_high;

  task automatic clear_obs();
    n_valid         = 0;
    last_valid_cyc  = -1;
    first_valid_cyc = -1;
    valid_gap       = 0;
    to_rise_cyc     = -1;
    to_fall_cyc     = -1;
    to_seen         = 1'b0;
  endtask

  // One clock cycle: drive, let the DUT and model take the edge, then compare.
  task automatic tick(input bit x, input bit r);
    in   = x;
    rstb = r;
    @(posedge clk);
    model_step(x, r);
    @(negedge clk);
    cyc++;
    check("valid",   valid,   32'(exp_valid));
    check("timeout", timeout, 32'(exp_timeout));
    check("period",  period,  32'(exp_period));
    check("high",    high,    32'(exp_high));
    if (valid === 1'b1) begin
      if (n_valid == 0) begin
        first_valid_cyc = cyc;
        fv_period       = period;
        fv_high         = high;
      end
      valid_gap      = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
      obs_period     = period;
      obs_high       = high;
      n_valid++;
    end
    if (timeout === 1'b1) to_seen = 1'b1;
    if (timeout === 1'b1 && !prev_to) to_rise_cyc = cyc;
    if (timeout === 1'b0 && prev_to)  to_fall_cyc = cyc;
    prev_to = (timeout === 1'b1);
  endtask

  task automatic hold(input bit x, input int n);
    for (int i = 0; i < n; i++) tick(x, 1'b1);
  endtask

  task automatic run_wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic do_reset(input bit x, input int n);
    for (int i = 0; i < n; i++) tick(x, 1'b0);
    clear_obs();
  endtask

  initial begin
    clear_obs();

    // Reset state
    do_reset(1'b0, 3);
    check("rst_period",  period,  0);
    check("rst_high",    high,    0);
    check("rst_valid",   valid,   0);
    check("rst_timeout", timeout, 0);

    // 1: period 100, high 30
    hold(1'b0, 5);
    run_wave(30, 70, 5);
    check("t1_count",  n_valid,   4);
    check("t1_period", fv_period, 100);
    check("t1_high",   fv_high,   30);
    check("t1_gap",    valid_gap, 100);
    check("t1_to",     to_seen,   0);

    // 3: stop the wave, then restart it
    hold(1'b0, 1100);
    check("t3_to_lat",  to_rise_cyc - last_valid_cyc, C_MAXC);
    check("t3_to",      timeout, 1);
    check("t3_period0", period,  0);
    check("t3_high0",   high,    0);
    clear_obs();
    run_wave(30, 70, 3);
    check("t3_count",     n_valid,     2);
    check("t3_to_clear",  to_fall_cyc, first_valid_cyc);
    check("t3_period",    fv_period,   100);

    // 2: pin high through reset release
    do_reset(1'b1, 3);
    hold(1'b1, 20);
    hold(1'b0, 25);
    run_wave(25, 25, 4);
    check("t2_count",  n_valid,   3);
    check("t2_period", fv_period, 50);
    check("t2_high",   fv_high,   25);

    // 4: period exactly at the limit, then one cycle over
    do_reset(1'b0, 2);
    hold(1'b0, 5);
    run_wave(400, 600, 3);
    check("t4_count",  n_valid,   2);
    check("t4_period", fv_period, 1000);
    check("t4_high",   fv_high,   400);
    check("t4_to",     to_seen,   0);
    do_reset(1'b0, 2);
    hold(1'b0, 5);
    run_wave(400, 601, 4);
    check("t4b_count", n_valid, 0);
    check("t4b_to",    to_seen, 1);

    // 5: fastest waveform
    do_reset(1'b0, 2);
    hold(1'b0, 3);
    run_wave(1, 2, 10);
    check("t5_count",  n_valid,    9);
    check("t5_period", obs_period, 3);
    check("t5_high",   obs_high,   1);
    check("t5_gap",    valid_gap,  3);

    // 6: one-cycle reset in the middle of a high phase
    do_reset(1'b0, 2);
    hold(1'b0, 5);
    run_wave(30, 70, 3);
    check("t6_pre_period", obs_period, 100);
    hold(1'b1, 10);
    tick(1'b1, 1'b0);
    check("t6_period", period,  0);
    check("t6_high",   high,    0);
    check("t6_valid",  valid,   0);
    check("t6_to",     timeout, 0);
    clear_obs();
    hold(1'b1, 20);
    hold(1'b0, 70);
    run_wave(30, 70, 3);
    check("t6_count",      n_valid,   2);
    check("t6_fv_period",  fv_period, 100);
    check("t6_fv_high",    fv_high,   30);

    // Randomized waveforms with occasional resets, checked each cycle
    for (int i = 0; i < 80; i++) begin
      int sel;
      int hi;
      int lo;
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        hi = $urandom_range(1, 40);
        lo = $urandom_range(1, 40);
      end else if (sel < 8) begin
        hi = $urandom_range(1, 500);
        lo = $urandom_range(1, 500);
      end else begin
        int p;
        p  = $urandom_range(995, 1005);
        hi = $urandom_range(1, p - 1);
        lo = p - hi;
      end
      if ($urandom_range(0, 19) == 0) begin
        tick(1'($urandom_range(0, 1)), 1'b0);
      end
      run_wave(hi, lo, $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow square wave, such as one produced by the design's square-wave generator or a looped-back sigma-delta bitstream divider, in clock cycles. It is the receiving end of the square-wave generator. The input is synchronised to `clk`, and its edges are detected. Each complete period is reported as a one-cycle `valid` strobe carrying the period and high time. A timeout flag is raised when no rising edge arrives within the programmed maximum period.

## Interface

Parameters:
- `C_CLK_FRQ`, default 100_000_000: clock frequency [Hz].
- `C_MAX_PERIOD`, default 1000: longest measurable period [ms].
- `C_SYNC_STAGES`, default 2: synchroniser depth (≥2).
- Derived `C_MAX_CYCLES` = C_CLK_FRQ * C_MAX_PERIOD / 1000.
- Derived `C_WIDTH` = $clog2(C_MAX_CYCLES + 1).

Ports:
- `clk`, input, 1: master clock.
- `rstb`, input, 1: reset, synchronous, active low.
- `in`, input, 1: asynchronous square wave to measure.
- `period`, output, C_WIDTH: last measured period in clk cycles.
- `high`, output, C_WIDTH: last measured high time in clk cycles.
- `valid`, output, 1: one-cycle strobe; `period`/`high` updated this cycle.
- `timeout`, output, 1: level; no rising edge within C_MAX_CYCLES.

One clock; reset is synchronous and active-low.

## Operation

**Front end**
- `C_SYNC_STAGES` flip-flop synchroniser, reset to 0, followed by a delay flip-flop.
- `rise` = synced & ~delayed; `fall` = ~synced & delayed.

**Counter**
- `rCount`, C_WIDTH bits, counts cycles since the last `rise`.
- On `rise`: rCount <= 1. Otherwise it increments, saturating at C_MAX_CYCLES.

**FSM**
- IDLE: waits for synced input = 0, then goes to ARMED. This discards edges caused by reset release or a stuck-high input.
- ARMED: on `rise`, goes to MEASURE and loads rCount <= 1. No `valid` is issued.
- MEASURE:
  - On `fall`: rHigh <= rCount (cycles from rise to fall).
  - On `rise`: period <= rCount, high <= rHigh, valid <= 1, timeout <= 0, rCount <= 1; stays in MEASURE.
  - On rCount == C_MAX_CYCLES with no `rise` this cycle: period <= 0, high <= 0, timeout <= 1, goes to IDLE.

**Boundary rules**
- A `rise` in the same cycle as rCount == C_MAX_CYCLES wins: valid measurement with period = C_MAX_CYCLES, no timeout.
- Minimum measurable waveform: high ≥1 cycle and low ≥1 cycle after synchronisation, giving period ≥2. Shorter pulses may be missed; no error is flagged.
- `timeout` stays high through IDLE and ARMED. It clears only together with the next `valid`.
- `period`/`high` hold their values between strobes.
- Reset mid-operation: aborts any measurement, with no partial output.

## Timing

- Reset values: `period` = 0, `high` = 0, `valid` = 0, `timeout` = 0, FSM = IDLE, synchroniser = 0, rCount = 0.
- Input edge to `rise`/`fall` detection: C_SYNC_STAGES + 1 cycles.
- `valid`, `period`, `high` are registered: they update in the cycle after the `rise` detection cycle.
- `valid` is high for exactly 1 cycle per measured period. There is no back-pressure; the consumer must sample on `valid`.
- `timeout` asserts 1 cycle after the cycle where rCount == C_MAX_CYCLES, i.e. C_MAX_CYCLES + 1 cycles after the last `rise` detection.
- Steady state: consecutive `valid` strobes are exactly `period` cycles apart.

## Test plan

Bench parameters: C_CLK_FRQ = 1_000_000, C_MAX_PERIOD = 1, giving C_MAX_CYCLES = 1000 and C_WIDTH = 10.

1. Input square wave, period 100 cycles, high 30 cycles → first `valid` after the second rising edge with period = 100, high = 30; `valid` repeats every 100 cycles; `timeout` = 0.
2. `in` held high through reset release, then toggled with period 50, high 25 → no `valid` before the first low phase has been followed by two rising edges; first `valid` reports period = 50, high = 25.
3. Run as in test 1, then hold `in` low → `timeout` rises 1001 cycles after the last `rise` detection; `period` = 0, `high` = 0; restarting the wave gives `timeout` = 0 together with the first new `valid`.
4. Period exactly 1000 cycles, high 400 → `valid` with period = 1000, high = 400, `timeout` never asserted. With period 1001 → `timeout` asserted, no `valid`.
5. Period 3 cycles, high 1 cycle (input changes synchronous to `clk`) → `valid` every 3 cycles with period = 3, high = 1.
6. `rstb` = 0 for 1 cycle midway through a period → next cycle all outputs are 0, FSM is IDLE; measurement resumes only after a low phase followed by two rises.
